eprisc_frameslave: RTL and testbench



---
 rtl/eprisc_frameslave.sv | 176 +++++++++++++++++
 tb/tb_eprisc_frameslave.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/eprisc_frameslave.sv
// Byte-framed bus slave: assembles {write, addr, data} frames from host strobes,
// issues one req/ack peripheral transaction and streams the read response back.
// Optional frame parity byte is enabled with `define FRAMESLAVE_PARITY_EN.
module eprisc_frameslave #(
   parameter int unsigned ADDR_W     = 15,
   parameter int unsigned DATA_W     = 16,
   parameter int unsigned RESP_BYTES = 4,
   parameter int unsigned TIMEOUT    = 15
) (
   input  logic                      iClk,
   input  logic                      iRst,
   input  logic                      iSelect,
   input  logic                      iStrobe,
   input  logic [7:0]                iMOSI,
   output logic [7:0]                oMISO,
   output logic                      oBusy,
   output logic                      oErr,
   output logic                      oReq,
   output logic                      oWrite,
   output logic [ADDR_W-1:0]         oAddr,
   output logic [DATA_W-1:0]         oWData,
   input  logic [8*RESP_BYTES-1:0]   iRData,
   input  logic                      iAck
);

   localparam int unsigned RD_W = 8 * RESP_BYTES;
   localparam int unsigned FW   = 1 + ADDR_W + DATA_W;
   localparam int unsigned NB   = (FW + 7) / 8;
`ifdef FRAMESLAVE_PARITY_EN
   localparam int unsigned NBT  = NB + 1;
`else
   localparam int unsigned NBT  = NB;
`endif
   localparam int unsigned BCW  = $clog2(NBT + 1);
   localparam int unsigned RCW  = $clog2(RESP_BYTES + 1);

   typedef enum logic [2:0] {IDLE, RECV, ISSUE, SEND, DONE} state_t;

   state_t            state;
   logic [8*NBT-1:0]  frame;
   logic [8*NBT-1:0]  next_frame;
   logic [BCW-1:0]    bcnt;
   logic [RCW-1:0]    rcnt;
   logic [7:0]        wcnt;
   logic [RD_W-1:0]   sreg;
   logic [RD_W-1:0]   shifted;
   logic              parity_ok;
   logic              frame_wr;

   // Frame as it will look once the byte on iMOSI is stored; lets the final
   // strobe decode the complete frame in the same cycle.
   always_comb begin
      next_frame = frame;
      for (int unsigned i = 0; i < NBT; i++) begin
         if (bcnt == BCW'(i)) next_frame[i*8 +: 8] = iMOSI;
      end
      frame_wr = next_frame[FW-1];
      shifted  = sreg >> 8;
`ifdef FRAMESLAVE_PARITY_EN
      begin
         logic [7:0] p;
         p = '0;
         for (int unsigned i = 0; i < NB; i++) p = p ^ next_frame[i*8 +: 8];
         parity_ok = (p == next_frame[NB*8 +: 8]);
      end
`else
      parity_ok = 1'b1;
`endif
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state  <= IDLE;
         frame  <= '0;
         bcnt   <= '0;
         rcnt   <= '0;
         wcnt   <= '0;
         sreg   <= '0;
         oMISO  <= '0;
         oBusy  <= 1'b0;
         oErr   <= 1'b0;
         oReq   <= 1'b0;
         oWrite <= 1'b0;
         oAddr  <= '0;
         oWData <= '0;
      end else begin
         oErr <= 1'b0;
         if (!iSelect) begin
            state <= IDLE;
            oReq  <= 1'b0;
            oBusy <= 1'b0;
            bcnt  <= '0;
            rcnt  <= '0;
            wcnt  <= '0;
            oMISO <= '0;
         end else begin
            case (state)
               IDLE, RECV: begin
                  state <= RECV;
                  if (iStrobe) begin
                     frame <= next_frame;
                     if (bcnt == BCW'(NBT - 1)) begin
                        bcnt   <= '0;
                        oWrite <= frame_wr;
                        oAddr  <= next_frame[DATA_W +: ADDR_W];
                        oWData <= next_frame[DATA_W-1:0];
                        if (parity_ok) begin
                           state <= ISSUE;
                           oReq  <= 1'b1;
                           oBusy <= 1'b1;
                           wcnt  <= '0;
                        end else begin
                           oErr <= 1'b1;
                           if (frame_wr) begin
                              state <= DONE;
                           end else begin
                              state <= SEND;
                              sreg  <= '1;
                              oMISO <= 8'hFF;
                              rcnt  <= '0;
                           end
                        end
                     end else begin
                        bcnt <= bcnt + BCW'(1);
                     end
                  end
               end
               ISSUE: begin
                  // Ack is checked first so a coincident timeout loses.
                  if (iAck) begin
                     oReq  <= 1'b0;
                     oBusy <= 1'b0;
                     if (oWrite) begin
                        state <= DONE;
                     end else begin
                        state <= SEND;
                        sreg  <= iRData;
                        oMISO <= iRData[7:0];
                        rcnt  <= '0;
                     end
                  end else if (wcnt == 8'(TIMEOUT - 1)) begin
                     oReq  <= 1'b0;
                     oBusy <= 1'b0;
                     oErr  <= 1'b1;
                     if (oWrite) begin
                        state <= DONE;
                     end else begin
                        state <= SEND;
                        sreg  <= '1;
                        oMISO <= 8'hFF;
                        rcnt  <= '0;
                     end
                  end else begin
                     wcnt <= wcnt + 8'd1;
                  end
               end
               SEND: begin
                  if (iStrobe) begin
                     if (rcnt == RCW'(RESP_BYTES - 1)) begin
                        state <= DONE;
                        oMISO <= '0;
                     end else begin
                        rcnt  <= rcnt + RCW'(1);
                        sreg  <= shifted;
                        oMISO <= shifted[7:0];
                     end
                  end
               end
               DONE:    state <= DONE;
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_eprisc_frameslave.sv
// Self-checking bench for eprisc_frameslave: directed scenarios plus randomized
// transactions checked against a frame/response reference model.
module tb_eprisc_frameslave;

   localparam int unsigned ADDR_W     = 15;
   localparam int unsigned DATA_W     = 16;
   localparam int unsigned RESP_BYTES = 4;
   localparam int unsigned TIMEOUT    = 15;
   localparam int unsigned RD_W       = 8 * RESP_BYTES;
   localparam int unsigned FW         = 1 + ADDR_W + DATA_W;
   localparam int unsigned NB         = (FW + 7) / 8;

   typedef logic [7:0] byte_q_t [$];

   logic              iClk = 1'b0;
   logic              iRst;
   logic              iSelect;
   logic              iStrobe;
   logic [7:0]        iMOSI;
   logic [7:0]        oMISO;
   logic              oBusy;
   logic              oErr;
   logic              oReq;
   logic              oWrite;
   logic [ADDR_W-1:0] oAddr;
   logic [DATA_W-1:0] oWData;
   logic [RD_W-1:0]   iRData;
   logic              iAck;

   int errors = 0;
   int checks = 0;

   eprisc_frameslave #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESP_BYTES(RESP_BYTES), .TIMEOUT(TIMEOUT)
   ) dut (
      .iClk(iClk), .iRst(iRst), .iSelect(iSelect), .iStrobe(iStrobe), .iMOSI(iMOSI),
      .oMISO(oMISO), .oBusy(oBusy), .oErr(oErr), .oReq(oReq), .oWrite(oWrite),
      .oAddr(oAddr), .oWData(oWData), .iRData(iRData), .iAck(iAck)
   );

   always #5 iClk = ~iClk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge iClk);
      #1;
   endtask

   // Reference frame: {write, addr, data} split LSB-first into bytes.
   function automatic byte_q_t make_frame(input logic wr, input logic [ADDR_W-1:0] a,
                                          input logic [DATA_W-1:0] d);
      logic [8*NB-1:0] f;
      logic [7:0]      p;
      byte_q_t         q;
      f = '0;
      f[FW-1:0] = {wr, a, d};
      p = '0;
      for (int unsigned i = 0; i < NB; i++) begin
         q.push_back(f[i*8 +: 8]);
         p = p ^ f[i*8 +: 8];
      end
`ifdef FRAMESLAVE_PARITY_EN
      q.push_back(p);
`endif
      return q;
   endfunction

   task automatic send_bytes(input byte_q_t q, input int unsigned n, input bit gaps);
      iSelect = 1'b1;
      for (int unsigned i = 0; i < n; i++) begin
         iMOSI   = q[i];
         iStrobe = 1'b1;
         tick();
         iStrobe = 1'b0;
         iMOSI   = 8'($urandom);
         if (gaps && i + 1 < n) repeat ($urandom_range(0, 2)) tick();
      end
   endtask

   task automatic run_txn(input logic wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                          input int unsigned ack_delay, input logic [RD_W-1:0] rdata, input bit noisy);
      byte_q_t         q;
      bit              acked;
      int unsigned     hi;
      logic [RD_W-1:0] resp;
      q = make_frame(wr, a, d);
      send_bytes(q, q.size(), noisy);
      check("req_rise", oReq, 1);
      check("busy_rise", oBusy, 1);
      check("write_flag", oWrite, wr);
      check("addr", oAddr, a);
      check("wdata", oWData, d);
      acked = ack_delay < TIMEOUT;
      hi = 0;
      for (int unsigned k = 0; k < TIMEOUT; k++) begin
         if (oReq) hi++;
         iAck    = (k == ack_delay);
         iRData  = iAck ? rdata : RD_W'({$urandom, $urandom});
         iStrobe = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
         iMOSI   = 8'($urandom);
         tick();
         iAck    = 1'b0;
         iStrobe = 1'b0;
         if (k == ack_delay) break;
      end
      check("req_cycles", hi, acked ? ack_delay + 1 : TIMEOUT);
      check("req_drop", oReq, 0);
      check("busy_drop", oBusy, 0);
      check("err_pulse", oErr, !acked);
      resp = acked ? rdata : '1;
      check("miso_first", oMISO, wr ? 8'h00 : resp[7:0]);
      tick();
      check("err_clear", oErr, 0);
      if (!wr) begin
         for (int unsigned i = 0; i < RESP_BYTES; i++) begin
            check("miso_byte", oMISO, resp[i*8 +: 8]);
            iStrobe = 1'b1;
            tick();
            iStrobe = 1'b0;
            if (noisy) repeat ($urandom_range(0, 2)) tick();
         end
      end
      check("miso_done", oMISO, 0);
      // DONE ignores strobes and stray acks
      iStrobe = 1'b1;
      iAck    = 1'b1;
      iMOSI   = 8'($urandom);
      tick();
      iStrobe = 1'b0;
      iAck    = 1'b0;
      check("done_miso", oMISO, 0);
      check("done_req", oReq, 0);
      check("addr_stable", oAddr, a);
      check("wdata_stable", oWData, d);
      iSelect = 1'b0;
      tick();
      check("idle_busy", oBusy, 0);
   endtask

   initial begin
      byte_q_t q;
      iRst = 1'b1; iSelect = 1'b0; iStrobe = 1'b0; iMOSI = '0; iRData = '0; iAck = 1'b0;
      tick();
      tick();
      check("rst_miso", oMISO, 0);
      check("rst_busy", oBusy, 0);
      check("rst_err", oErr, 0);
      check("rst_req", oReq, 0);
      check("rst_write", oWrite, 0);
      check("rst_addr", oAddr, 0);
      check("rst_wdata", oWData, 0);
      iRst = 1'b0;
      tick();

      run_txn(1'b1, 15'h0005, 16'h1234, 3, '0, 1'b0);
      run_txn(1'b0, 15'h0010, 16'h0000, 0, 32'hDEADBEEF, 1'b0);
      run_txn(1'b0, 15'h0010, 16'h0000, TIMEOUT + 5, 32'h12345678, 1'b0);
      run_txn(1'b0, 15'h1234, 16'h5555, TIMEOUT - 1, 32'hCAFEF00D, 1'b0);
      run_txn(1'b1, 15'h7FFF, 16'hFFFF, TIMEOUT + 1, '0, 1'b0);

      // Deselect after byte 2: partial frame is discarded
      q = make_frame(1'b1, 15'h2AAA, 16'hBEEF);
      send_bytes(q, 3, 1'b0);
      iSelect = 1'b0;
      tick();
      check("abort_req", oReq, 0);
      check("abort_busy", oBusy, 0);
      tick();
      check("abort_req_hold", oReq, 0);
      run_txn(1'b0, 15'h0ABC, 16'h0F0F, 2, 32'hA5A5_5A5A, 1'b0);

      // Reset mid-frame
      q = make_frame(1'b1, 15'h0001, 16'h0002);
      send_bytes(q, 2, 1'b0);
      iRst = 1'b1;
      iSelect = 1'b0;
      tick();
      iRst = 1'b0;
      check("midrst_req", oReq, 0);
      check("midrst_addr", oAddr, 0);
      tick();
      check("midrst_req_hold", oReq, 0);
      run_txn(1'b1, 15'h0321, 16'h4567, 1, '0, 1'b0);

`ifdef FRAMESLAVE_PARITY_EN
      q = make_frame(1'b1, 15'h0005, 16'h1234);
      q[NB] = 8'h00;
      send_bytes(q, q.size(), 1'b0);
      check("par_no_req", oReq, 0);
      check("par_err", oErr, 1);
      tick();
      check("par_err_clear", oErr, 0);
      check("par_req_hold", oReq, 0);
      iSelect = 1'b0;
      tick();
      q = make_frame(1'b0, 15'h0005, 16'h1234);
      q[NB] = q[NB] ^ 8'h01;
      send_bytes(q, q.size(), 1'b0);
      check("par_rd_err", oErr, 1);
      check("par_rd_miso", oMISO, 8'hFF);
      iSelect = 1'b0;
      tick();
`endif

      for (int n = 0; n < 24; n++) begin
         run_txn(1'($urandom), ADDR_W'($urandom), DATA_W'($urandom),
                 $urandom_range(0, TIMEOUT + 2), RD_W'({$urandom, $urandom}), 1'b1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

endmodule
